// File: rtl/ysyx_22041211_dmem_resp.sv
// Data-memory responder: one load/store at a time over valid/ready, word-wide SRAM model
// with a fixed access latency. Define DMEM_RAND_DELAY_EN to add an LFSR-driven random extra wait of 0..3 cycles.
module ysyx_22041211_dmem_resp #(
    parameter int unsigned          DATA_LEN   = 32,
    parameter int unsigned          DEPTH_LOG2 = 10,
    parameter logic [DATA_LEN-1:0]  BASE_ADDR  = DATA_LEN'(32'h8000_0000),
    parameter int unsigned          LATENCY    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_wen,
    input  logic [DATA_LEN-1:0] req_addr,
    input  logic [DATA_LEN-1:0] req_wdata,
    input  logic [3:0]          req_wmask,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_LEN-1:0] resp_rdata,
    output logic                resp_err
);

    localparam int unsigned LANE_W = DATA_LEN / 4;
    localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W  = $clog2(LATENCY + 5);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t              state;
    logic                wen_q;
    logic [DATA_LEN-1:0] addr_q;
    logic [DATA_LEN-1:0] wdata_q;
    logic [3:0]          wmask_q;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    wait_len_q;
    logic [CNT_W-1:0]    wait_len_c;
    logic [DATA_LEN-1:0] mem [DEPTH];

    logic                  req_fire_c;
    logic                  do_access_c;
    logic                  acc_wen_c;
    logic [DATA_LEN-1:0]   acc_addr_c;
    logic [DATA_LEN-1:0]   acc_wdata_c;
    logic [3:0]            acc_wmask_c;
    logic [DATA_LEN-1:0]   acc_off_c;
    logic [DATA_LEN-1:0]   word_off_c;
    logic                  acc_in_range_c;
    logic [DEPTH_LOG2-1:0] acc_idx_c;
    logic                  mem_we_c;

    // Ready only while idle and out of reset
    assign req_ready  = (state == S_IDLE) && !rst;
    assign req_fire_c = req_valid && req_ready;

`ifdef DMEM_RAND_DELAY_EN
    logic [15:0] lfsr;

    // Fibonacci LFSR, taps 16/14/13/11
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign wait_len_c = CNT_W'(LATENCY) + CNT_W'(lfsr[1:0]);
`else
    assign wait_len_c = CNT_W'(LATENCY);
`endif

    // A zero-length wait performs the access on the handshake edge itself, so use live request fields
    always_comb begin
        acc_wen_c   = wen_q;
        acc_addr_c  = addr_q;
        acc_wdata_c = wdata_q;
        acc_wmask_c = wmask_q;
        if (state == S_IDLE) begin
            acc_wen_c   = req_wen;
            acc_addr_c  = req_addr;
            acc_wdata_c = req_wdata;
            acc_wmask_c = req_wmask;
        end
        do_access_c = ((state == S_IDLE) && req_fire_c && (wait_len_c == '0)) ||
                      ((state == S_WAIT) && (cnt == wait_len_q - CNT_W'(1)));
        acc_off_c      = acc_addr_c - BASE_ADDR;
        word_off_c     = acc_off_c >> 2;
        acc_in_range_c = (acc_addr_c >= BASE_ADDR) && ((word_off_c >> DEPTH_LOG2) == '0);
        acc_idx_c      = word_off_c[DEPTH_LOG2-1:0];
        mem_we_c       = do_access_c && acc_wen_c && acc_in_range_c && !rst;
    end

    // Byte-lane writes; contents are never reset
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_wmask_c[i]) begin
                    mem[acc_idx_c][i*LANE_W +: LANE_W] <= acc_wdata_c[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    // Control FSM with registered response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            cnt        <= '0;
            wait_len_q <= '0;
            wen_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wmask_q    <= '0;
        end else begin
            if (do_access_c) begin
                resp_valid <= 1'b1;
                resp_err   <= !acc_in_range_c;
                resp_rdata <= (!acc_wen_c && acc_in_range_c) ? mem[acc_idx_c] : '0;
            end
            case (state)
                S_IDLE: begin
                    if (req_fire_c) begin
                        wen_q      <= req_wen;
                        addr_q     <= req_addr;
                        wdata_q    <= req_wdata;
                        wmask_q    <= req_wmask;
                        wait_len_q <= wait_len_c;
                        cnt        <= '0;
                        state      <= (wait_len_c == '0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt == wait_len_q - CNT_W'(1)) begin
                        cnt   <= '0;
                        state <= S_RESP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22041211_dmem_resp.sv
// Directed bench for ysyx_22041211_dmem_resp (LATENCY=2, random delay disabled).
module tb_ysyx_22041211_dmem_resp;

    localparam int unsigned LAT = 2;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wmask;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int total = 0;
    int bad   = 0;

    ysyx_22041211_dmem_resp #(
        .DATA_LEN   (32),
        .DEPTH_LOG2 (10),
        .BASE_ADDR  (32'h8000_0000),
        .LATENCY    (LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wen    (req_wen),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wmask  (req_wmask),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a request and complete its handshake; returns in the cycle after the handshake
    task automatic do_req(input string tag, input logic wen, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wmask);
        int n = 0;
        req_valid = 1'b1;
        req_wen   = wen;
        req_addr  = addr;
        req_wdata = wdata;
        req_wmask = wmask;
        #1;
        while (req_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_rdy"}, 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
    endtask

    // Wait for the response, check latency and payload, optionally consume it
    task automatic wait_resp(input string tag, input logic [31:0] exp_d, input logic exp_e,
                             input bit consume);
        int n = 0;
        while (resp_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'(LAT));
        chk({tag, "_vld"}, 32'(resp_valid), 32'd1);
        chk({tag, "_data"}, resp_rdata, exp_d);
        chk({tag, "_err"}, 32'(resp_err), 32'(exp_e));
        if (consume) tick();
    endtask

    task automatic xact(input string tag, input logic wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wmask,
                        input logic [31:0] exp_d, input logic exp_e);
        do_req(tag, wen, addr, wdata, wmask);
        wait_resp(tag, exp_d, exp_e, 1'b1);
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_wen    = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_wmask  = '0;
        resp_ready = 1'b1;

        // Reset held for two cycles
        tick();
        tick();
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        rst = 1'b0;
        #1;
        chk("idle_req_ready", 32'(req_ready), 32'd1);

        // Seed word 0, then store/load round trip
        xact("st_w0", 1'b1, 32'h8000_0000, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0);
        xact("st_full", 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0);
        xact("ld_full", 1'b0, 32'h8000_0010, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0);

        // Partial store into lane 1; ignored low address bits
        xact("st_part", 1'b1, 32'h8000_0010, 32'h0000_5500, 4'b0010, 32'h0, 1'b0);
        xact("ld_part", 1'b0, 32'h8000_0013, 32'h0, 4'h0, 32'hDEAD_55EF, 1'b0);

        // Empty mask leaves memory unchanged
        xact("st_nomask", 1'b1, 32'h8000_0010, 32'h1234_5678, 4'h0, 32'h0, 1'b0);
        xact("ld_nomask", 1'b0, 32'h8000_0010, 32'h0, 4'h0, 32'hDEAD_55EF, 1'b0);

        // Backpressure: response held, second request waits
        resp_ready = 1'b0;
        do_req("bp_first", 1'b0, 32'h8000_0010, 32'h0, 4'h0);
        wait_resp("bp_first", 32'hDEAD_55EF, 1'b0, 1'b0);
        req_valid = 1'b1;
        req_wen   = 1'b0;
        req_addr  = 32'h8000_0000;
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_vld", 32'(resp_valid), 32'd1);
            chk("bp_hold_data", resp_rdata, 32'hDEAD_55EF);
            chk("bp_hold_rdy", 32'(req_ready), 32'd0);
            tick();
        end
        resp_ready = 1'b1;
        #1;
        chk("bp_release_vld", 32'(resp_valid), 32'd1);
        tick();
        chk("bp_after_vld", 32'(resp_valid), 32'd0);
        chk("bp_after_rdy", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        #1;
        chk("bp_second_taken", 32'(req_ready), 32'd0);
        wait_resp("bp_second", 32'hCAFE_F00D, 1'b0, 1'b1);

        // Out of range below base and one past the end; top word is in range
        xact("oor_lo", 1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0, 32'h0, 1'b1);
        xact("oor_hi", 1'b1, 32'h8000_1000, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1);
        xact("ld_w0", 1'b0, 32'h8000_0000, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0);
        xact("st_top", 1'b1, 32'h8000_0FFC, 32'hA5A5_5A5A, 4'hF, 32'h0, 1'b0);
        xact("ld_top", 1'b0, 32'h8000_0FFC, 32'h0, 4'h0, 32'hA5A5_5A5A, 1'b0);

        // Reset during WAIT drops the pending store
        xact("st_x20", 1'b1, 32'h8000_0020, 32'h1111_1111, 4'hF, 32'h0, 1'b0);
        do_req("st_drop", 1'b1, 32'h8000_0020, 32'h2222_2222, 4'hF);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("midrst_vld", 32'(resp_valid), 32'd0);
        chk("midrst_rdy", 32'(req_ready), 32'd1);
        tick();
        chk("midrst_idle_vld", 32'(resp_valid), 32'd0);
        xact("ld_x20", 1'b0, 32'h8000_0020, 32'h0, 4'h0, 32'h1111_1111, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
